// File: rtl/timer_unit.sv
// Memory-mapped cycle counter with programmable target and level interrupt to CP0.
// Latency: count reads are combinational; interrupt asserts the cycle after count==target.
// Backpressure: none; every load/store is serviced in the cycle it is presented.
module timer_unit #(
  parameter logic [31:0] TIMER_ADDR  = 32'hFFFF001C,
  parameter logic [31:0] ACK_ADDR    = 32'hFFFF006C,
  parameter logic [31:0] CYCLE_RESET = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] cycle,
  output logic        TimerInterrupt,
  output logic        TimerAddress
);

  logic [31:0] cycle_count;
  logic [31:0] interrupt_cycle;
  logic        interrupt_line;

  logic        timer_hit;
  logic        ack_hit;
  logic        target_wr;
  logic        ack_wr;
  logic        match;

  // Address decode and the compare against the pre-edge register values.
  always_comb begin
    timer_hit = (address == TIMER_ADDR);
    ack_hit   = (address == ACK_ADDR);
    target_wr = MemWrite && timer_hit;
    ack_wr    = MemWrite && ack_hit;
    match     = (cycle_count == interrupt_cycle);
  end

  // Free-running counter; wraps silently at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count <= 32'h0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // Target register; a new value only affects the compare from the next cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      interrupt_cycle <= CYCLE_RESET;
    end else if (target_wr) begin
      interrupt_cycle <= data;
    end
  end

  // Sticky interrupt: a match wins over a same-cycle acknowledge so none is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      interrupt_line <= 1'b0;
    end else if (match) begin
      interrupt_line <= 1'b1;
    end else if (ack_wr) begin
      interrupt_line <= 1'b0;
    end
  end

  // Load mux steering and read data; ACK_ADDR reads return zero.
  always_comb begin
    TimerAddress   = timer_hit || ack_hit;
    cycle          = (MemRead && timer_hit) ? cycle_count : 32'h0;
    TimerInterrupt = interrupt_line;
  end

endmodule

// File: tb/tb_timer_unit.sv
module tb_timer_unit;

  localparam logic [31:0] TIMER_ADDR = 32'hFFFF001C;
  localparam logic [31:0] ACK_ADDR   = 32'hFFFF006C;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] cycle;
  logic        TimerInterrupt;
  logic        TimerAddress;

  int          vec;
  int          err;
  logic [31:0] tb_cnt;

  timer_unit dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .data(data),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .cycle(cycle),
    .TimerInterrupt(TimerInterrupt),
    .TimerAddress(TimerAddress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    logic r;
    r = reset;
    @(posedge clk);
    #1;
    if (r) tb_cnt = tb_cnt + 32'd1;
    else   tb_cnt = 32'h0;
  endtask

  task automatic idle();
    address  = 32'h0;
    data     = 32'h0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  // Present a load from TIMER_ADDR and return the read data (no edge).
  task automatic peek_count(output logic [31:0] v);
    address = TIMER_ADDR;
    MemRead = 1'b1;
    #1;
    v = cycle;
    idle();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    address  = a;
    data     = d;
    MemWrite = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0;
    idle();
    tick();
    tick();
    vec++;
    if (TimerInterrupt !== 1'b0) begin
      err++; $display("FAIL reset_irq got %b want 0", TimerInterrupt);
    end
    vec++;
    if (cycle !== 32'h0) begin
      err++; $display("FAIL reset_cycle_idle got %h want 0", cycle);
    end
    vec++;
    if (dut.interrupt_cycle !== 32'hFFFFFFFF) begin
      err++; $display("FAIL reset_target got %h want ffffffff", dut.interrupt_cycle);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    address = TIMER_ADDR;
    MemRead = 1'b1;
    #1;
    vec++;
    if (cycle !== 32'd5) begin
      err++; $display("FAIL count_after_5 got %0d want 5", cycle);
    end
    vec++;
    if (TimerAddress !== 1'b1) begin
      err++; $display("FAIL timer_addr_decode got %b want 1", TimerAddress);
    end
    vec++;
    if (TimerInterrupt !== 1'b0) begin
      err++; $display("FAIL irq_after_5 got %b want 0", TimerInterrupt);
    end
    idle();
    peek_count(v);
    vec++;
    if (v !== tb_cnt) begin
      err++; $display("FAIL count_model got %0d want %0d", v, tb_cnt);
    end
  endtask

  task automatic test_program_fire();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    store(TIMER_ADDR, 32'd20);
    while (tb_cnt <= 32'd20) begin
      vec++;
      if (TimerInterrupt !== 1'b0) begin
        err++; $display("FAIL irq_early count=%0d got %b want 0", tb_cnt, TimerInterrupt);
      end
      tick();
    end
    while (tb_cnt < 32'd30) begin
      vec++;
      if (TimerInterrupt !== 1'b1) begin
        err++; $display("FAIL irq_fire count=%0d got %b want 1", tb_cnt, TimerInterrupt);
      end
      tick();
    end
    store(ACK_ADDR, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (TimerInterrupt !== 1'b0) begin
        err++; $display("FAIL irq_ack count=%0d got %b want 0", tb_cnt, TimerInterrupt);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous_set_ack();
    store(TIMER_ADDR, tb_cnt + 32'd2);
    tick();
    tick();
    vec++;
    if (TimerInterrupt !== 1'b1) begin
      err++; $display("FAIL irq_pending count=%0d got %b want 1", tb_cnt, TimerInterrupt);
    end
    store(TIMER_ADDR, 32'd40);
    while (tb_cnt < 32'd40) tick();
    store(ACK_ADDR, 32'h0);
    vec++;
    if (TimerInterrupt !== 1'b1) begin
      err++; $display("FAIL set_beats_ack count=%0d got %b want 1", tb_cnt, TimerInterrupt);
    end
    tick();
    vec++;
    if (TimerInterrupt !== 1'b1) begin
      err++; $display("FAIL irq_hold count=%0d got %b want 1", tb_cnt, TimerInterrupt);
    end
    store(ACK_ADDR, 32'h0);
    vec++;
    if (TimerInterrupt !== 1'b0) begin
      err++; $display("FAIL ack_after_set count=%0d got %b want 0", tb_cnt, TimerInterrupt);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    logic [31:0] want;
    store(TIMER_ADDR, 32'd2);
    force dut.cycle_count = 32'hFFFFFFFD;
    #1;
    release dut.cycle_count;
    tb_cnt = 32'hFFFFFFFD;
    peek_count(v);
    vec++;
    if (v !== 32'hFFFFFFFD) begin
      err++; $display("FAIL wrap_preset got %h want fffffffd", v);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      want = 32'hFFFFFFFE + i;
      peek_count(v);
      vec++;
      if (v !== want) begin
        err++; $display("FAIL wrap_count step=%0d got %h want %h", i, v, want);
      end
      vec++;
      if (TimerInterrupt !== 1'b0) begin
        err++; $display("FAIL wrap_irq_early count=%h got %b want 0", v, TimerInterrupt);
      end
    end
    tick();
    peek_count(v);
    vec++;
    if (v !== 32'd3 || TimerInterrupt !== 1'b1) begin
      err++; $display("FAIL wrap_fire count=%h irq=%b want count=3 irq=1", v, TimerInterrupt);
    end
  endtask

  task automatic test_decode();
    logic [31:0] v;
    address  = 32'hFFFF0018;
    data     = 32'h5;
    MemWrite = 1'b1;
    #1;
    vec++;
    if (TimerAddress !== 1'b0) begin
      err++; $display("FAIL decode_near got %b want 0", TimerAddress);
    end
    tick();
    address = 32'h10010000;
    #1;
    vec++;
    if (TimerAddress !== 1'b0) begin
      err++; $display("FAIL decode_dmem got %b want 0", TimerAddress);
    end
    tick();
    idle();
    vec++;
    if (dut.interrupt_cycle !== 32'd2) begin
      err++; $display("FAIL decode_target got %h want 2", dut.interrupt_cycle);
    end
    address = ACK_ADDR;
    MemRead = 1'b1;
    #1;
    vec++;
    if (cycle !== 32'h0 || TimerAddress !== 1'b1) begin
      err++; $display("FAIL ack_read cycle=%h taddr=%b want cycle=0 taddr=1", cycle, TimerAddress);
    end
    tick();
    idle();
    vec++;
    if (TimerInterrupt !== 1'b1) begin
      err++; $display("FAIL ack_read_side_effect got %b want 1", TimerInterrupt);
    end
    address = 32'h10010000;
    MemRead = 1'b1;
    #1;
    vec++;
    if (cycle !== 32'h0) begin
      err++; $display("FAIL other_read got %h want 0", cycle);
    end
    address  = TIMER_ADDR;
    MemWrite = 1'b1;
    data     = 32'd100;
    #1;
    vec++;
    if (cycle !== tb_cnt) begin
      err++; $display("FAIL rw_read got %0d want %0d", cycle, tb_cnt);
    end
    tick();
    idle();
    vec++;
    if (dut.interrupt_cycle !== 32'd100) begin
      err++; $display("FAIL rw_write got %0d want 100", dut.interrupt_cycle);
    end
    peek_count(v);
    vec++;
    if (v !== tb_cnt) begin
      err++; $display("FAIL rw_count got %0d want %0d", v, tb_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    vec++;
    if (TimerInterrupt !== 1'b1) begin
      err++; $display("FAIL mid_pre_irq got %b want 1", TimerInterrupt);
    end
    reset    = 1'b0;
    address  = TIMER_ADDR;
    data     = 32'd7;
    MemWrite = 1'b1;
    tick();
    idle();
    vec++;
    if (TimerInterrupt !== 1'b0) begin
      err++; $display("FAIL mid_irq got %b want 0", TimerInterrupt);
    end
    vec++;
    if (dut.interrupt_cycle !== 32'hFFFFFFFF) begin
      err++; $display("FAIL mid_target got %h want ffffffff", dut.interrupt_cycle);
    end
    peek_count(v);
    vec++;
    if (v !== 32'h0) begin
      err++; $display("FAIL mid_count got %0d want 0", v);
    end
    reset = 1'b1;
    tick();
    peek_count(v);
    vec++;
    if (v !== 32'd1) begin
      err++; $display("FAIL mid_restart got %0d want 1", v);
    end
  endtask

  initial begin
    vec    = 0;
    err    = 0;
    tb_cnt = 32'h0;
    reset  = 1'b0;
    idle();
    #1;
    test_reset();
    test_program_fire();
    test_simultaneous_set_ack();
    test_wrap();
    test_decode();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/timer_unit.md
# timer_unit

Memory-mapped cycle timer for the single-cycle MIPS machine, sitting directly downstream of the ALU on the data-memory side. It decodes the ALU-computed address alongside data memory. It counts elapsed cycles, lets software program a target cycle and read the current count. It raises a level-sensitive timer interrupt toward coprocessor 0 and holds it until software acknowledges it.

## Interface
Parameters:
- TIMER_ADDR, 32'hFFFF001C, address for reading the cycle count and writing the interrupt-target cycle
- ACK_ADDR, 32'hFFFF006C, address whose write acknowledges (clears) the interrupt
- CYCLE_RESET, 32'hFFFFFFFF, reset value of the interrupt-target register

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low: state is reset at a rising clk edge where reset==0
- address  in  32  data address (ALU output)
- data  in  32  store data (rt read value)
- MemRead  in  1  load in progress this cycle
- MemWrite  in  1  store in progress this cycle
- cycle  out  32  current cycle count on a load from TIMER_ADDR, else 0
- TimerInterrupt  out  1  interrupt request to coprocessor 0, registered
- TimerAddress  out  1  combinational: address equals TIMER_ADDR or ACK_ADDR; steers the load mux and suppresses data-memory access

## Operation
- State: cycle_count[31:0], interrupt_cycle[31:0], interrupt_line (1 bit).
- cycle_count: +1 every edge with reset==1. Modulo 2^32; 32'hFFFFFFFF wraps to 0 with no flag.
- interrupt_cycle: loads data at an edge where MemWrite==1 and address==TIMER_ADDR. Otherwise it holds.
- match = (cycle_count == interrupt_cycle). Compare uses the pre-edge register values. A write to interrupt_cycle affects match starting the following cycle.
- interrupt_line next value:
  - set to 1 if match
  - else cleared to 0 if MemWrite==1 and address==ACK_ADDR
  - else holds
  - Set has priority over acknowledge when both occur in the same cycle, so no interrupt is lost.
- TimerInterrupt = interrupt_line.
- cycle = cycle_count when MemRead==1 and address==TIMER_ADDR, else 32'h0. The read returns the pre-edge value.
- Reads of ACK_ADDR return 0 and have no side effect.
- Writes to ACK_ADDR: data is ignored.
- Any other address, or MemRead/MemWrite both 0: no state change except counting.
- MemRead and MemWrite both 1 at TIMER_ADDR: the read returns the old count and the write loads interrupt_cycle; the two actions are independent.
- Re-arming: software writes a new interrupt_cycle. Until then, match recurs once per 2^32 cycles.

## Timing
- Reset values: cycle_count=0, interrupt_cycle=CYCLE_RESET, interrupt_line=0.
- Resulting output values under reset: TimerInterrupt=0; cycle=0 unless a TIMER_ADDR read is presented.
- Reset mid-operation: all three registers return to their reset values at that edge, including a pending interrupt. Writes in the same cycle are discarded.
- After reset deasserts, cycle_count equals k after k rising edges with reset==1.
- Interrupt latency: at the edge where cycle_count==T and interrupt_cycle==T, interrupt_line goes 1. TimerInterrupt is therefore first high in the cycle where cycle_count==T+1.
- Ack latency: TimerInterrupt falls in the cycle after the ACK_ADDR store.
- The default CYCLE_RESET fires once when the count reaches 32'hFFFFFFFF, unless reprogrammed first.
- TimerAddress and cycle are purely combinational from address and MemRead, valid in the same cycle.

## Test plan
- Reset and count:
  - Stimulus: hold reset=0 for 2 edges, then release; load TIMER_ADDR after 5 edges.
  - Required: cycle=5, TimerInterrupt=0, TimerAddress=1.
- Program and fire:
  - Stimulus: store 32'd20 to TIMER_ADDR at count 3.
  - Required: TimerInterrupt=0 through count 20; TimerInterrupt=1 at count 21 and holding.
  - Then store to ACK_ADDR at count 30. Required: TimerInterrupt=0 at count 31 and stays 0.
- Simultaneous set/ack:
  - Stimulus: interrupt pending; set interrupt_cycle=40; store to ACK_ADDR in the cycle where count==40.
  - Required: TimerInterrupt stays 1 at count 41.
- Wrap-around:
  - Stimulus: program interrupt_cycle=2; drive the counter past 32'hFFFFFFFF (shorten via force or a long run).
  - Required: count wraps to 0, 1, 2, and the interrupt fires again at count 3.
- Decode isolation:
  - Stimulus: store 32'h5 to 32'hFFFF0018 and 32'h10010000; load from ACK_ADDR.
  - Required: interrupt_cycle unchanged; TimerAddress=0 for both stores; ACK_ADDR read gives cycle=0 with TimerAddress=1.
- Reset mid-interrupt:
  - Stimulus: TimerInterrupt=1, then reset=0 for 1 edge.
  - Required: TimerInterrupt=0, interrupt_cycle=32'hFFFFFFFF, count restarts at 0.
